// File: rtl/axi_lite_mem_scheduler_if.sv
// AXI4-Lite master/slave bundle used by the fetch/data memory scheduler.
// Signal names follow the M_AXI_* channel names without the prefix.
interface axi_lite_mem_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int PROT_W = 3,
  parameter int RESP_W = 2
);
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [PROT_W-1:0] AWPROT;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID;
  logic              BREADY;
  logic [RESP_W-1:0] BRESP;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [PROT_W-1:0] ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [RESP_W-1:0] RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT,
    output WVALID, WDATA, WSTRB,
    output BREADY,
    output ARVALID, ARADDR, ARPROT,
    output RREADY,
    input  AWREADY, WREADY,
    input  BVALID, BRESP,
    input  ARREADY,
    input  RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT,
    input  WVALID, WDATA, WSTRB,
    input  BREADY,
    input  ARVALID, ARADDR, ARPROT,
    input  RREADY,
    output AWREADY, WREADY,
    output BVALID, BRESP,
    output ARREADY,
    output RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_mem_scheduler.sv
// Round-robin scheduler sharing one AXI4-Lite master between fetch and
// data requesters, with a sticky watchdog for a stalled slave.
module axi_lite_mem_scheduler #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_STROBE_WIDTH = 4,
  parameter int AXI_PROT_WIDTH   = 3,
  parameter int AXI_RESP_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES   = 256,
  parameter logic [AXI_PROT_WIDTH-1:0] FETCH_PROT = 3'b100,
  parameter logic [AXI_PROT_WIDTH-1:0] DATA_PROT  = 3'b000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        if_req,
  input  logic [AXI_ADDR_WIDTH-1:0]   if_addr,
  output logic                        if_done,
  output logic [DATA_WIDTH-1:0]       if_rdata,
  output logic                        if_err,
  input  logic                        d_req,
  input  logic                        d_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]       d_wdata,
  input  logic [AXI_STROBE_WIDTH-1:0] d_wstrb,
  output logic                        d_done,
  output logic [DATA_WIDTH-1:0]       d_rdata,
  output logic                        d_err,
  output logic                        hang,
  axi_lite_mem_scheduler_if.master    m_axi
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WRESP
  } state_e;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int WD_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_PROT_WIDTH-1:0] prot_q, prot_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic if_done_q, if_done_d;
  logic d_done_q, d_done_d;
  logic if_err_q, if_err_d;
  logic d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic hang_q, hang_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic f_ok, d_ok, grant_f;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  always_comb begin
    ar_hs = arvalid_q & m_axi.ARREADY;
    r_hs  = rready_q & m_axi.RVALID;
    aw_hs = awvalid_q & m_axi.AWREADY;
    w_hs  = wvalid_q & m_axi.WREADY;
    b_hs  = bready_q & m_axi.BVALID;
    // A requester is ignored in its own done cycle: its req is still high.
    f_ok    = if_req & ~if_done_q;
    d_ok    = d_req & ~d_done_q;
    grant_f = f_ok & (~d_ok | (last_q == OWN_D));

    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    prot_d     = prot_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_err_d   = if_err_q;
    d_err_d    = d_err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_f) begin
          owner_d   = OWN_F;
          last_d    = OWN_F;
          addr_d    = if_addr;
          prot_d    = FETCH_PROT;
          arvalid_d = 1'b1;
          state_d   = RADDR;
        end else if (d_ok) begin
          owner_d = OWN_D;
          last_d  = OWN_D;
          addr_d  = d_addr;
          prot_d  = DATA_PROT;
          wdata_d = d_wdata;
          wstrb_d = d_wstrb;
          if (d_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          rready_d = 1'b0;
          state_d  = IDLE;
          if (owner_q == OWN_F) begin
            if_rdata_d = m_axi.RDATA;
            if_err_d   = (m_axi.RRESP != '0);
            if_done_d  = 1'b1;
          end else begin
            d_rdata_d = m_axi.RDATA;
            d_err_d   = (m_axi.RRESP != '0);
            d_done_d  = 1'b1;
          end
        end
      end
      WADDR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!(awvalid_q & ~aw_hs) && !(wvalid_q & ~w_hs)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (b_hs) begin
          bready_d  = 1'b0;
          d_rdata_d = '0;
          d_err_d   = (m_axi.BRESP != '0);
          d_done_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wd_d = wd_q;
    if (state_q == IDLE || ar_hs || r_hs || aw_hs || w_hs || b_hs)
      wd_d = '0;
    else if (wd_q != WD_MAX)
      wd_d = wd_q + 1'b1;
    hang_d = hang_q | ((TIMEOUT_CYCLES != 0) && (wd_d == WD_MAX));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= OWN_F;
      last_q     <= OWN_D;
      addr_q     <= '0;
      prot_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      hang_q     <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      prot_q     <= prot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      hang_q     <= hang_d;
      wd_q       <= wd_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_rdata = if_rdata_q;
  assign if_err   = if_err_q;
  assign d_done   = d_done_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;
  assign hang     = hang_q;

  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARPROT  = prot_q;
  assign m_axi.RREADY  = rready_q;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWPROT  = prot_q;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = wstrb_q;
  assign m_axi.BREADY  = bready_q;

endmodule

// File: tb/tb_axi_lite_mem_scheduler.sv
// Directed bench for axi_lite_mem_scheduler with a small AXI4-Lite
// memory model (addresses >= 0x100 answer with an error response).
module tb_axi_lite_mem_scheduler;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        hang;

  axi_lite_mem_scheduler_if axi ();

  axi_lite_mem_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_done(d_done),
    .d_rdata(d_rdata), .d_err(d_err), .hang(hang),
    .m_axi(axi)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [0:63];
  logic        ar_never = 1'b0;
  logic        b_never = 1'b0;
  int          aw_wait = 0;
  int          aw_cnt;
  logic        rvalid, bvalid, aw_got, w_got;
  logic [31:0] rdata_s, awa, wd;
  logic [1:0]  rresp_s, bresp_s;
  logic [3:0]  ws;

  assign axi.ARREADY = axi.ARVALID & ~ar_never;
  assign axi.AWREADY = axi.AWVALID & (aw_cnt >= aw_wait);
  assign axi.WREADY  = axi.WVALID;
  assign axi.RVALID  = rvalid;
  assign axi.RDATA   = rdata_s;
  assign axi.RRESP   = rresp_s;
  assign axi.BVALID  = bvalid;
  assign axi.BRESP   = bresp_s;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid <= 1'b0; bvalid <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
      rdata_s <= '0; rresp_s <= '0; bresp_s <= '0;
      awa <= '0; wd <= '0; ws <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= {4{i[7:0]}};
      mem[2] <= 32'h0000_006F;
      mem[4] <= 32'h1122_3344;
    end else begin
      if (axi.ARVALID && axi.ARREADY) begin
        rvalid <= 1'b1;
        if (axi.ARADDR < 32'h100) begin
          rdata_s <= mem[axi.ARADDR[7:2]]; rresp_s <= 2'b00;
        end else begin
          rdata_s <= 32'hBADB_AD00; rresp_s <= 2'b11;
        end
      end
      if (rvalid && axi.RREADY) rvalid <= 1'b0;
      if (axi.AWVALID && !axi.AWREADY) aw_cnt <= aw_cnt + 1;
      if (axi.AWVALID && axi.AWREADY) begin
        aw_cnt <= 0; aw_got <= 1'b1; awa <= axi.AWADDR;
      end
      if (axi.WVALID && axi.WREADY) begin
        w_got <= 1'b1; wd <= axi.WDATA; ws <= axi.WSTRB;
      end
      if (aw_got && w_got && !bvalid && !b_never) begin
        bvalid <= 1'b1;
        aw_got <= 1'b0; w_got <= 1'b0;
        bresp_s <= (awa < 32'h100) ? 2'b00 : 2'b10;
        if (awa < 32'h100)
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[awa[7:2]][8*b +: 8] <= wd[8*b +: 8];
      end
      if (bvalid && axi.BREADY) bvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int chk = 0;
  int errs = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [2:0]  exp_prot;
  } vec_t;

  task automatic run_req(input vec_t v, input string nm,
                         output logic [31:0] rd, output logic er,
                         output int lat, output logic [2:0] prot);
    bit seen;
    seen = 0; lat = 0; rd = '0; er = 1'b0; prot = 3'b111;
    @(negedge CLK);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr;
      d_wdata = v.wdata; d_wstrb = v.strb;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge CLK);
      if (axi.ARVALID) prot = axi.ARPROT;
      if (axi.AWVALID) prot = axi.AWPROT;
      if (v.is_d ? d_done : if_done) begin
        seen = 1; lat = n;
        rd = v.is_d ? d_rdata : if_rdata;
        er = v.is_d ? d_err : if_err;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    if (!seen) begin
      chk++; errs++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  vec_t vt [7];
  logic [31:0] rd;
  logic er;
  int lat;
  logic [2:0] prot;
  int ndone, saw_aw_only, bready_early, saw_bready, overlap, nd;
  logic [3:0] order;
  bit hit;

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 32'h0000_006F, 1'b0, 3, 3'b100};
    vt[1] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 4, 3'b000};
    vt[2] = '{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h1122_BEEF, 1'b0, 3, 3'b000};
    vt[3] = '{1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'hBADB_AD00, 1'b1, 3, 3'b000};
    vt[4] = '{1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h0505_0505, 1'b0, 3, 3'b000};
    vt[5] = '{1'b1, 1'b1, 32'h300, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 4, 3'b000};
    vt[6] = '{1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0303_0303, 1'b0, 3, 3'b100};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_ctrl",
          {31'd0, if_done | d_done | if_err | d_err | hang | axi.ARVALID |
           axi.AWVALID | axi.WVALID | axi.BREADY | axi.RREADY}, 32'd0);
    check("reset_addr", axi.ARADDR, 32'd0);
    check("reset_wstrb", {28'd0, axi.WSTRB}, 32'd0);
    check("reset_rdata", if_rdata | d_rdata, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_req(vt[i], $sformatf("vec%0d", i), rd, er, lat, prot);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d_prot", i), {29'd0, prot}, {29'd0, vt[i].exp_prot});
    end

    // Store with AWREADY held off two cycles, WREADY immediate.
    aw_wait = 2;
    ndone = 0; saw_aw_only = 0; bready_early = 0; saw_bready = 0;
    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h18;
    d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (axi.AWVALID && !axi.WVALID) saw_aw_only++;
      if (axi.BREADY && (axi.AWVALID || axi.WVALID)) bready_early++;
      if (axi.BREADY) saw_bready++;
      if (d_done) begin
        ndone++; d_req = 1'b0;
        check("store_derr", {31'd0, d_err}, 32'd0);
      end
    end
    d_req = 1'b0;
    aw_wait = 0;
    check("store_aw_only_cycles", saw_aw_only, 2);
    check("store_bready_early", bready_early, 0);
    check("store_bready_seen", {31'd0, saw_bready != 0}, 32'd1);
    check("store_done_count", ndone, 1);
    run_req('{1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 32'h0, 1'b0, 0, 3'b0},
            "store_rb", rd, er, lat, prot);
    check("store_readback", rd, 32'hCAFE_F00D);

    // Reset while waiting in WRESP.
    b_never = 1'b1;
    hit = 0;
    @(negedge CLK);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24;
    d_wdata = 32'h5555_AAAA; d_wstrb = 4'hF;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge CLK);
      if (axi.BREADY) hit = 1;
    end
    check("wresp_reached", {31'd0, hit}, 32'd1);
    #2 RST = 1'b1;
    #1 check("rst_bready", {31'd0, axi.BREADY}, 32'd0);
    d_req = 1'b0; b_never = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Both requesters held: grants alternate, fetch first after reset.
    @(negedge CLK);
    if_req = 1'b1; if_addr = 32'h08;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
    d_wdata = 32'h0BAD_F00D; d_wstrb = 4'hF;
    nd = 0; overlap = 0; order = 4'hF;
    for (int n = 0; n < 100 && nd < 4; n++) begin
      @(negedge CLK);
      if (axi.ARVALID && axi.AWVALID) overlap++;
      if (if_done) begin order[nd] = 1'b0; nd++; end
      if (d_done && nd < 4) begin order[nd] = 1'b1; nd++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("rr_done_count", nd, 4);
    check("rr_order", {28'd0, order}, 32'b1010);
    check("rr_no_overlap", overlap, 0);

    // Watchdog: ARREADY never comes.
    repeat (2) @(negedge CLK);
    ar_never = 1'b1;
    if_req = 1'b1; if_addr = 32'h04;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      if (n == 7) check("hang_low_c7", {31'd0, hang}, 32'd0);
      if (n == 9) check("hang_high_c9", {31'd0, hang}, 32'd1);
      if (n == 12) check("hang_arvalid_held", {31'd0, axi.ARVALID}, 32'd1);
    end
    #2 RST = 1'b1;
    #1 check("rst_clears_hang", {30'd0, hang, axi.ARVALID}, 32'd0);
    @(negedge CLK);
    if_req = 1'b0; ar_never = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    run_req(vt[0], "post_rst", rd, er, lat, prot);
    check("post_rst_rdata", rd, 32'h0000_006F);
    check("post_rst_hang", {31'd0, hang}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
